// File: rtl/execute_mem_agu_sched_pkg.sv
// Shared memory-execute definitions: access size encodings, tag width default,
// kseg translation mask and the size-dependent alignment check.
package execute_mem_agu_sched_pkg;

  localparam int TAG_W_DEF = 5;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

  localparam logic [31:0] KSEG_PHYS_MASK = 32'h1FFF_FFFF;

  // Size 3 is treated as a word access.
  function automatic logic mem_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      MEM_SIZE_BYTE: return 1'b0;
      MEM_SIZE_HALF: return addr_lo[0];
      default:       return |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/execute_mem_agu_sched_agu.sv
// Memory address generation: base + sign-extended imm16, then fixed kseg0/kseg1
// translation (strip top 3 bits, kseg1 uncached); purely combinational.
module execute_mem_agu
  import execute_mem_agu_sched_pkg::*;
(
  input  logic [31:0] src0,
  input  logic [15:0] imm,
  output logic [31:0] vaddr,
  output logic [31:0] paddr,
  output logic        uncached
);

  always_comb begin
    vaddr    = src0 + {{16{imm[15]}}, imm};
    uncached = (vaddr[31:29] == 3'b101);
    paddr    = (vaddr[31:30] == 2'b10) ? (vaddr & KSEG_PHYS_MASK) : vaddr;
  end

endmodule

// File: rtl/execute_mem_agu_sched.sv
// Round-robin load/store issue into one shared AGU, registered into a single
// valid/ready output slot (1-cycle latency; a full stalled slot blocks both requesters).
module execute_mem_agu_sched
  import execute_mem_agu_sched_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_flush,
  input  logic             i_ld_valid,
  output logic             o_ld_ready,
  input  logic [31:0]      i_ld_src0,
  input  logic [25:0]      i_ld_imm,
  input  logic [1:0]       i_ld_size,
  input  logic [TAG_W-1:0] i_ld_tag,
  input  logic             i_st_valid,
  output logic             o_st_ready,
  input  logic [31:0]      i_st_src0,
  input  logic [25:0]      i_st_imm,
  input  logic [1:0]       i_st_size,
  input  logic [TAG_W-1:0] i_st_tag,
  input  logic [31:0]      i_st_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_vaddr,
  output logic [31:0]      o_paddr,
  output logic             o_uncached,
  output logic             o_store,
  output logic [1:0]       o_size,
  output logic [TAG_W-1:0] o_tag,
  output logic [31:0]      o_data,
  output logic             o_misalign
);

  typedef struct packed {
    logic [31:0]      vaddr;
    logic [31:0]      paddr;
    logic             uncached;
    logic             store;
    logic [1:0]       size;
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
    logic             misalign;
  } slot_t;

  slot_t       slot_q;
  slot_t       slot_d;
  logic        valid_q;
  logic        prio;
  logic        accept;
  logic        grant_ld;
  logic        grant_st;
  logic [31:0] agu_src0;
  logic [15:0] agu_imm;
  logic [31:0] agu_vaddr;
  logic [31:0] agu_paddr;
  logic        agu_uncached;
  logic [1:0]  sel_size;
  logic        unused_imm_hi;

  assign unused_imm_hi = ^{i_ld_imm[25:16], i_st_imm[25:16]};

  assign accept   = !i_flush && (!valid_q || i_ready);
  // prio = 1 means the store requester wins a tie.
  assign grant_ld = i_ld_valid && (!i_st_valid || !prio);
  assign grant_st = i_st_valid && (!i_ld_valid || prio);

  assign o_ld_ready = accept && grant_ld;
  assign o_st_ready = accept && grant_st;

  assign agu_src0 = grant_st ? i_st_src0 : i_ld_src0;
  assign agu_imm  = grant_st ? i_st_imm[15:0] : i_ld_imm[15:0];
  assign sel_size = grant_st ? i_st_size : i_ld_size;

  execute_mem_agu u_agu (
    .src0     (agu_src0),
    .imm      (agu_imm),
    .vaddr    (agu_vaddr),
    .paddr    (agu_paddr),
    .uncached (agu_uncached)
  );

  always_comb begin
    slot_d          = '0;
    slot_d.vaddr    = agu_vaddr;
    slot_d.paddr    = agu_paddr;
    slot_d.uncached = agu_uncached;
    slot_d.store    = grant_st;
    slot_d.size     = sel_size;
    slot_d.tag      = grant_st ? i_st_tag : i_ld_tag;
    slot_d.data     = grant_st ? i_st_data : 32'd0;
    slot_d.misalign = mem_misaligned(sel_size, agu_vaddr[1:0]);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      slot_q  <= '0;
      prio    <= 1'b0;
    end else if (i_flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= grant_ld || grant_st;
      if (grant_ld || grant_st) begin
        slot_q <= slot_d;
        prio   <= grant_ld;
      end
    end
  end

  assign o_valid    = valid_q;
  assign o_vaddr    = slot_q.vaddr;
  assign o_paddr    = slot_q.paddr;
  assign o_uncached = slot_q.uncached;
  assign o_store    = slot_q.store;
  assign o_size     = slot_q.size;
  assign o_tag      = slot_q.tag;
  assign o_data     = slot_q.data;
  assign o_misalign = slot_q.misalign;

endmodule

// File: tb/tb_execute_mem_agu_sched.sv
// Randomised and directed bench for execute_mem_agu_sched against an
// address-arithmetic reference model of the scheduler.
module tb_execute_mem_agu_sched;

  localparam int TW = 5;
  localparam int VW = 1 + 32 + 32 + 1 + 1 + 2 + TW + 32 + 1;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          flush = 1'b0;
  logic          ld_valid = 1'b0;
  logic          ld_ready;
  logic [31:0]   ld_src0 = '0;
  logic [25:0]   ld_imm = '0;
  logic [1:0]    ld_size = '0;
  logic [TW-1:0] ld_tag = '0;
  logic          st_valid = 1'b0;
  logic          st_ready;
  logic [31:0]   st_src0 = '0;
  logic [25:0]   st_imm = '0;
  logic [1:0]    st_size = '0;
  logic [TW-1:0] st_tag = '0;
  logic [31:0]   st_data = '0;
  logic          out_valid;
  logic          rdy = 1'b0;
  logic [31:0]   out_vaddr, out_paddr, out_data;
  logic          out_uncached, out_store, out_misalign;
  logic [1:0]    out_size;
  logic [TW-1:0] out_tag;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic          m_valid, m_prio_st, m_unc, m_store, m_mis;
  logic [31:0]   m_vaddr, m_paddr, m_data;
  logic [1:0]    m_size;
  logic [TW-1:0] m_tag;
  logic          exp_ldr, exp_str, obs_ldr, obs_str;

  execute_mem_agu_sched #(.TAG_W(TW)) dut (
    .clk(clk), .resetn(resetn), .i_flush(flush),
    .i_ld_valid(ld_valid), .o_ld_ready(ld_ready), .i_ld_src0(ld_src0), .i_ld_imm(ld_imm),
    .i_ld_size(ld_size), .i_ld_tag(ld_tag),
    .i_st_valid(st_valid), .o_st_ready(st_ready), .i_st_src0(st_src0), .i_st_imm(st_imm),
    .i_st_size(st_size), .i_st_tag(st_tag), .i_st_data(st_data),
    .o_valid(out_valid), .i_ready(rdy), .o_vaddr(out_vaddr), .o_paddr(out_paddr),
    .o_uncached(out_uncached), .o_store(out_store), .o_size(out_size), .o_tag(out_tag),
    .o_data(out_data), .o_misalign(out_misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_vaddr(input logic [31:0] s, input logic [25:0] imm);
    logic signed [15:0] off;
    off = imm[15:0];
    return s + 32'(off);
  endfunction

  function automatic logic [31:0] ref_paddr(input logic [31:0] v);
    if (v >= 32'hA000_0000 && v <= 32'hBFFF_FFFF) return v - 32'hA000_0000;
    if (v >= 32'h8000_0000 && v <  32'hA000_0000) return v - 32'h8000_0000;
    return v;
  endfunction

  function automatic logic ref_misalign(input logic [31:0] v, input logic [1:0] sz);
    int bytes;
    bytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    return (v % bytes) != 0;
  endfunction

  // 0 = nobody, 1 = load, 2 = store
  function automatic int pick_winner();
    if (ld_valid && st_valid) return m_prio_st ? 2 : 1;
    if (ld_valid) return 1;
    if (st_valid) return 2;
    return 0;
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {m_valid, m_vaddr, m_paddr, m_unc, m_store, m_size, m_tag, m_data, m_mis};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {out_valid, out_vaddr, out_paddr, out_uncached, out_store, out_size, out_tag, out_data, out_misalign};
  endfunction

  task automatic model_reset();
    m_valid = 0; m_prio_st = 0; m_unc = 0; m_store = 0; m_mis = 0;
    m_vaddr = 0; m_paddr = 0; m_data = 0; m_size = 0; m_tag = 0;
  endtask

  task automatic model_edge();
    bit acc;
    int w;
    acc = !flush && (!m_valid || rdy);
    w = pick_winner();
    if (flush) m_valid = 0;
    else if (acc) begin
      if (w == 0) m_valid = 0;
      else begin
        m_valid   = 1;
        m_store   = (w == 2);
        m_vaddr   = (w == 2) ? ref_vaddr(st_src0, st_imm) : ref_vaddr(ld_src0, ld_imm);
        m_size    = (w == 2) ? st_size : ld_size;
        m_tag     = (w == 2) ? st_tag : ld_tag;
        m_data    = (w == 2) ? st_data : 32'd0;
        m_paddr   = ref_paddr(m_vaddr);
        m_unc     = (m_vaddr >= 32'hA000_0000 && m_vaddr <= 32'hBFFF_FFFF);
        m_mis     = ref_misalign(m_vaddr, m_size);
        m_prio_st = (w == 1);
      end
    end
  endtask

  // Inputs are driven right after a posedge; readies are sampled at the negedge.
  task automatic tick();
    bit acc;
    int w;
    @(negedge clk);
    acc = !flush && (!m_valid || rdy);
    w = pick_winner();
    exp_ldr = acc && (w == 1);
    exp_str = acc && (w == 2);
    obs_ldr = ld_ready;
    obs_str = st_ready;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; ld_valid = 0; st_valid = 0; rdy = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ld(input logic [31:0] s, input logic [25:0] imm, input logic [1:0] sz, input logic [TW-1:0] tg);
    ld_valid = 1; ld_src0 = s; ld_imm = imm; ld_size = sz; ld_tag = tg;
  endtask

  task automatic set_st(input logic [31:0] s, input logic [25:0] imm, input logic [1:0] sz, input logic [TW-1:0] tg, input logic [31:0] d);
    st_valid = 1; st_src0 = s; st_imm = imm; st_size = sz; st_tag = tg; st_data = d;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dut_vec() !== {VW{1'b0}}) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", dut_vec());
    end
    checks++;
    if ({ld_ready, st_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_readies: got %b want 00", {ld_ready, st_ready});
    end
  endtask

  task automatic test_load_only();
    do_reset();
    rdy = 1;
    set_ld(32'h8000_1000, 26'h000_FFFC, 2'd2, 5'd3);
    tick();
    checks++;
    if ({obs_ldr, obs_str} !== 2'b10) begin
      errors++; $display("FAIL load_only_ready: got %b want 10", {obs_ldr, obs_str});
    end
    checks++;
    if (out_vaddr !== 32'h8000_0FFC || out_store !== 1'b0 || out_data !== 32'd0 || out_misalign !== 1'b0 || out_tag !== 5'd3 || out_valid !== 1'b1) begin
      errors++; $display("FAIL load_only_fields: got vaddr=%h st=%b data=%h mis=%b tag=%0d v=%b want vaddr=80000ffc st=0 data=0 mis=0 tag=3 v=1",
                         out_vaddr, out_store, out_data, out_misalign, out_tag, out_valid);
    end
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL load_only_slot: got %h want %h", dut_vec(), exp_vec());
    end
    ld_valid = 0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] seq;
    do_reset();
    rdy = 1;
    set_ld(32'h0000_2000, 26'h000_0010, 2'd2, 5'd1);
    set_st(32'h0000_3000, 26'h000_0020, 2'd2, 5'd2, 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) begin
      tick();
      seq[i] = out_store;
      checks++;
      if ({obs_ldr, obs_str} !== {exp_ldr, exp_str} || dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL alternate_cycle%0d: got rd=%b %h want rd=%b %h", i, {obs_ldr, obs_str}, dut_vec(), {exp_ldr, exp_str}, exp_vec());
      end
    end
    checks++;
    if (seq !== 4'b1010) begin
      errors++; $display("FAIL alternate_store_seq: got %b want 1010 (cycle3..0)", seq);
    end
  endtask

  task automatic test_stall();
    logic [VW-1:0] snap;
    rdy = 0;
    snap = dut_vec();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({obs_ldr, obs_str} !== 2'b00 || dut_vec() !== snap) begin
        errors++; $display("FAIL stall_hold%0d: got rd=%b %h want rd=00 %h", i, {obs_ldr, obs_str}, dut_vec(), snap);
      end
    end
    rdy = 1;
    tick();
    checks++;
    if ({obs_ldr, obs_str} !== {exp_ldr, exp_str} || ({exp_ldr, exp_str} == 2'b00) || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL stall_release: got rd=%b %h want rd=%b %h", {obs_ldr, obs_str}, dut_vec(), {exp_ldr, exp_str}, exp_vec());
    end
  endtask

  task automatic test_flush();
    logic prio_before;
    st_valid = 0;
    set_ld(32'h0000_4000, 26'h000_0004, 2'd0, 5'd7);
    rdy = 1;
    flush = 1;
    prio_before = m_prio_st;
    tick();
    checks++;
    if (obs_ldr !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_kill: got ldr=%b valid=%b want ldr=0 valid=0", obs_ldr, out_valid);
    end
    flush = 0;
    set_st(32'h0000_5000, 26'h000_0008, 2'd2, 5'd9, 32'h1234_5678);
    tick();
    checks++;
    if ({obs_ldr, obs_str} !== (prio_before ? 2'b01 : 2'b10) || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL flush_prio_hold: got rd=%b want rd=%b", {obs_ldr, obs_str}, prio_before ? 2'b01 : 2'b10);
    end
    idle_inputs();
    rdy = 1;
    tick();
  endtask

  task automatic test_uncached_misalign();
    rdy = 1;
    set_st(32'hA000_0001, 26'h0, 2'd1, 5'd4, 32'hCAFE_0001);
    tick();
    st_valid = 0;
    checks++;
    if (out_vaddr !== 32'hA000_0001 || out_uncached !== 1'b1 || out_misalign !== 1'b1 || out_paddr !== 32'h0000_0001 || out_store !== 1'b1) begin
      errors++; $display("FAIL kseg1_half: got vaddr=%h pa=%h unc=%b mis=%b st=%b want a0000001 00000001 1 1 1",
                         out_vaddr, out_paddr, out_uncached, out_misalign, out_store);
    end
    set_st(32'hA000_0001, 26'h0, 2'd0, 5'd5, 32'hCAFE_0002);
    tick();
    st_valid = 0;
    checks++;
    if (out_misalign !== 1'b0 || out_data !== 32'hCAFE_0002 || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL kseg1_byte: got mis=%b data=%h want mis=0 data=cafe0002", out_misalign, out_data);
    end
  endtask

  task automatic test_wrap_and_async_reset();
    rdy = 1;
    set_ld(32'hFFFF_FFFE, 26'h3FF_0004, 2'd1, 5'd6);
    tick();
    ld_valid = 0;
    checks++;
    if (out_vaddr !== 32'h0000_0002 || out_misalign !== 1'b0 || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL wrap_vaddr: got %h mis=%b want 00000002 mis=0", out_vaddr, out_misalign);
    end
    rdy = 0;
    tick();
    #2;
    resetn = 0;
    model_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || dut_vec() !== {VW{1'b0}}) begin
      errors++; $display("FAIL async_reset_stall: got %h want 0", dut_vec());
    end
    do_reset();
  endtask

  task automatic new_src(output logic [31:0] s);
    logic [31:0] r;
    r = $urandom & 32'h1FFF_FFFF;
    case ($urandom_range(0, 3))
      0: s = r;
      1: s = 32'h8000_0000 | r;
      2: s = 32'hA000_0000 | r;
      default: s = 32'hE000_0000 | r;
    endcase
  endtask

  task automatic test_random();
    logic [31:0] s;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (!ld_valid || obs_ldr) begin
        new_src(s);
        ld_valid = ($urandom_range(0, 2) != 0);
        ld_src0 = s; ld_imm = 26'($urandom); ld_size = 2'($urandom); ld_tag = TW'($urandom);
      end
      if (!st_valid || obs_str) begin
        new_src(s);
        st_valid = ($urandom_range(0, 2) != 0);
        st_src0 = s; st_imm = 26'($urandom); st_size = 2'($urandom); st_tag = TW'($urandom);
        st_data = $urandom;
      end
      rdy   = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0);
      tick();
      checks++;
      if ({obs_ldr, obs_str} !== {exp_ldr, exp_str} || dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL random_cycle%0d: got rd=%b %h want rd=%b %h", i, {obs_ldr, obs_str}, dut_vec(), {exp_ldr, exp_str}, exp_vec());
      end
    end
    idle_inputs();
  endtask

  initial begin
    obs_ldr = 0; obs_str = 0; exp_ldr = 0; exp_str = 0;
    model_reset();
    test_reset();
    test_load_only();
    test_back_to_back();
    test_stall();
    test_flush();
    test_uncached_misalign();
    test_wrap_and_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_mem_agu_sched.md
# execute_mem_agu_sched

Issue scheduler for the memory-stage address generation unit. Shares the single `execute_mem_agu` between a load requester and a store requester using round-robin arbitration. Registers the translated address, the alignment check and the request payload into one output slot with a valid/ready handshake toward the LSU. Sits between the memory issue queues and the LSU, and supports pipeline flush.

## Interface
- `TAG_W`, default 5: width of the requester tag carried with each request.

- `clk`  in  1: clock.
- `resetn`  in  1: asynchronous active-low reset.
- `i_flush`  in  1: pipeline flush; kills the output slot and blocks acceptance this cycle.
- `i_ld_valid`  in  1: load request valid.
- `o_ld_ready`  out  1: load request accepted this cycle.
- `i_ld_src0`  in  32: load base register value.
- `i_ld_imm`  in  26: load immediate field; only [15:0] used, sign-extended.
- `i_ld_size`  in  2: load access size. 0 = byte, 1 = half, 2 = word, 3 = word.
- `i_ld_tag`  in  TAG_W: load tag.
- `i_st_valid`, `o_st_ready`, `i_st_src0`, `i_st_imm`, `i_st_size`, `i_st_tag`: same as the load ports, for the store requester.
- `i_st_data`  in  32: store data, carried through unchanged.
- `o_valid`  out  1: output slot holds a result.
- `i_ready`  in  1: LSU accepts the slot.
- `o_vaddr`  out  32: virtual address.
- `o_paddr`  out  32: physical address.
- `o_uncached`  out  1: kseg1 access.
- `o_store`  out  1: 1 = store, 0 = load.
- `o_size`  out  2: access size.
- `o_tag`  out  TAG_W: tag.
- `o_data`  out  32: store data; 0 for loads.
- `o_misalign`  out  1: address misaligned for `o_size`.

## Operation
- `accept = !i_flush && (!o_valid || i_ready)`.
- Arbitration, using the 1-bit `prio` register (0 = load first):
  - both requests valid: grant the requester selected by `prio`;
  - one request valid: grant it.
- `o_ld_ready = accept && grant_ld`; `o_st_ready = accept && grant_st`.
  - At most one ready is high per cycle.
  - Ready may depend combinationally on both valids.
- On a grant:
  - `prio` becomes the non-granted requester.
  - No grant: `prio` holds.
  - Flush cycle: `prio` holds.
- The granted request's src0 and imm drive one `execute_mem_agu` instance.
  - vaddr = src0 + sext(imm[15:0]), mod 2^32; wrap-around is silent.
  - paddr and uncached come from the AGU.
- Misalignment:
  - size 1: `vaddr[0] != 0`;
  - size 2 or 3: `vaddr[1:0] != 0`;
  - size 0: never misaligned.
  - A misaligned request is still accepted and presented, with `o_misalign = 1`.
- On accept with a grant, the slot loads vaddr, paddr, uncached, store, size, tag, data (store data, or 0 for a load) and misalign; `o_valid` is then 1.
- On accept without a grant, `o_valid` becomes 0.
- While `o_valid && !i_ready`, all outputs hold stable.
- `i_flush`: `o_valid` is 0 next cycle; payload registers may hold stale values.
  - `o_valid && i_ready` in a flush cycle is not a transfer; the LSU is flushed as well.

## Timing
- Reset (async assert, sync release on `clk`): `o_valid` = 0, all payload outputs = 0, `prio` = 0.
- Latency: a request accepted at edge N is on the outputs after edge N (`o_valid` = 1 in cycle N+1).
- Throughput: 1 request per cycle while `i_ready` is held high; back-to-back grants alternate when both requesters stay valid.
- A full slot with `i_ready` = 0 gives both readies = 0; no request is dropped.
- Reset asserted mid-stall discards the slot immediately (asynchronous).
- Requester valid/payload must stay stable until its ready is seen; the scheduler does not check this.

## Structure
- The shared memory-execute package holds the size encodings (`MEM_SIZE_BYTE/HALF/WORD`) and the `TAG_W` default.
- Sub-module: one `execute_mem_agu` instance, fed from the arbitration mux.
- All other logic is inline: arbiter mux, `prio` flop, alignment check, output slot register.

## Test plan
- Load only, src0 = 0x8000_1000, imm = 0xFFFC, size 2, tag 3, `i_ready` = 1:
  - ready in cycle 0;
  - cycle 1: vaddr = 0x8000_0FFC, store = 0, data = 0, misalign = 0, tag = 3.
- Load and store both valid for 4 cycles, `i_ready` = 1 → grants L, S, L, S from reset; `o_store` sequence 0, 1, 0, 1.
- Slot full, `i_ready` = 0 for 3 cycles with both requests valid:
  - both readies = 0, outputs unchanged;
  - `i_ready` → 1 transfers the slot and accepts the next request the same cycle.
- Store with src0 = 0xA000_0001, imm = 0, size 1:
  - vaddr = 0xA000_0001, uncached = 1, misalign = 1;
  - same address with size 0 gives misalign = 0.
- `i_flush` with the slot valid and a load valid: `o_ld_ready` = 0, `o_valid` = 0 next cycle, `prio` unchanged.
- src0 = 0xFFFF_FFFE, imm = 0x0004 → vaddr = 0x0000_0002 (wrap-around); `resetn` pulsed low mid-stall → `o_valid` = 0 at once.
